// File: rtl/ram_mult_engine.sv
// Compute master on the FPGA port of the shared on-chip RAM: polls the CSR word,
// multiplies COUNT operand pairs (signed or unsigned) and writes double-width products back.
//
// state  | meaning
// IDLE   | wait POLL_INT cycles between control-word polls
// POLL   | read CSR word 0, decide on GO
// START  | write CSR with BUSY set, check COUNT
// RD_A   | read operand A of pair i
// RD_B   | read operand B of pair i
// MUL    | wait for the multiplier pipeline
// WR_LO  | write low product word
// WR_HI  | write high product word, advance pair index
// FINISH | write CSR with DONE (and ERR), pulse done_pulse
module ram_mult_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int MAX_PAIRS  = 16,
    parameter int RES_BASE   = 64,
    parameter int RD_LAT     = 1,
    parameter int MUL_STAGES = 3,
    parameter int POLL_INT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_W-1:0]     ram_address,
    output logic                  ram_chipselect,
    output logic                  ram_clken,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic                  busy,
    output logic                  done_pulse
);

    localparam int IDX_W = $clog2(MAX_PAIRS + 1);
    localparam int CNT_W = $clog2(POLL_INT + RD_LAT + MUL_STAGES + 1);
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL,
        S_START,
        S_RD_A,
        S_RD_B,
        S_MUL,
        S_WR_LO,
        S_WR_HI,
        S_FINISH
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_load;

    logic [7:0]           count_q;
    logic                 signed_q;
    logic                 err_q;
    logic [IDX_W-1:0]     idx;
    logic [DATA_W-1:0]    op_a;
    logic [DATA_W-1:0]    op_b;

    logic                 count_bad;
    logic                 last_pair;
    logic                 rd_strobe;
    logic                 cnt_tc;
    logic [ADDR_W-1:0]    idx2;

    logic [2*DATA_W-1:0]  ext_a;
    logic [2*DATA_W-1:0]  ext_b;
    logic [2*DATA_W-1:0]  prod;
    logic [2*DATA_W-1:0]  pipe [MUL_STAGES];

    assign cnt_tc    = (cnt == '0);
    assign rd_strobe = (cnt == CNT_W'(RD_LAT));
    assign count_bad = ({1'b0, count_q} > 9'(MAX_PAIRS));
    assign last_pair = ((9'(idx) + 9'd1) >= {1'b0, count_q});
    assign idx2      = ADDR_W'({idx, 1'b0});

    // Extending both operands to full product width makes the truncated product
    // correct for either signedness.
    assign ext_a = {{DATA_W{signed_q & op_a[DATA_W-1]}}, op_a};
    assign ext_b = {{DATA_W{signed_q & op_b[DATA_W-1]}}, op_b};
    assign prod  = ext_a * ext_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= cnt_load;
            end else if (!cnt_tc) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cnt_tc) state_nxt = S_POLL;
            S_POLL:   if (cnt_tc) state_nxt = ram_readdata[0] ? S_START : S_IDLE;
            S_START:  state_nxt = (count_q == 8'd0 || count_bad) ? S_FINISH : S_RD_A;
            S_RD_A:   if (cnt_tc) state_nxt = S_RD_B;
            S_RD_B:   if (cnt_tc) state_nxt = S_MUL;
            S_MUL:    if (cnt_tc) state_nxt = S_WR_LO;
            S_WR_LO:  state_nxt = S_WR_HI;
            S_WR_HI:  state_nxt = last_pair ? S_FINISH : S_RD_A;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Timer load for the state being entered; each state leaves on terminal count.
    always_comb begin
        cnt_load = '0;
        case (state_nxt)
            S_IDLE:                 cnt_load = CNT_W'(POLL_INT - 1);
            S_POLL, S_RD_A, S_RD_B: cnt_load = CNT_W'(RD_LAT);
            S_MUL:                  cnt_load = CNT_W'(MUL_STAGES - 1);
            default:                cnt_load = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                S_POLL: begin
                    if (cnt_tc && ram_readdata[0]) begin
                        count_q  <= ram_readdata[15:8];
                        signed_q <= ram_readdata[3];
                        err_q    <= 1'b0;
                        idx      <= '0;
                    end
                end
                S_START: err_q <= count_bad;
                S_WR_HI: if (!last_pair) idx <= idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_RD_A && cnt_tc) op_a <= ram_readdata;
        if (state == S_RD_B && cnt_tc) op_b <= ram_readdata;
    end

    always_ff @(posedge clk) begin
        pipe[0] <= prod;
        for (int k = 1; k < MUL_STAGES; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end

    always_comb begin
        ram_address    = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        done_pulse     = 1'b0;
        busy           = 1'b0;
        case (state)
            S_POLL: begin
                ram_chipselect = rd_strobe;
            end
            S_START: begin
                busy              = 1'b1;
                ram_chipselect    = 1'b1;
                ram_write         = 1'b1;
                ram_writedata[15:8] = count_q;
                ram_writedata[3]  = signed_q;
                ram_writedata[1]  = 1'b1;
            end
            S_RD_A: begin
                busy           = 1'b1;
                ram_chipselect = rd_strobe;
                ram_address    = idx2 + ADDR_W'(1);
            end
            S_RD_B: begin
                busy           = 1'b1;
                ram_chipselect = rd_strobe;
                ram_address    = idx2 + ADDR_W'(2);
            end
            S_MUL: begin
                busy = 1'b1;
            end
            S_WR_LO: begin
                busy           = 1'b1;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = ADDR_W'(RES_BASE) + idx2;
                ram_writedata  = pipe[MUL_STAGES-1][DATA_W-1:0];
            end
            S_WR_HI: begin
                busy           = 1'b1;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = ADDR_W'(RES_BASE) + idx2 + ADDR_W'(1);
                ram_writedata  = pipe[MUL_STAGES-1][2*DATA_W-1:DATA_W];
            end
            S_FINISH: begin
                busy              = 1'b1;
                done_pulse        = 1'b1;
                ram_chipselect    = 1'b1;
                ram_write         = 1'b1;
                ram_writedata[15:8] = count_q;
                ram_writedata[3]  = signed_q;
                ram_writedata[4]  = err_q;
                ram_writedata[2]  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ram_clken      = ram_chipselect;
    assign ram_byteenable = {BE_W{ram_chipselect}};

endmodule

// File: tb/tb_ram_mult_engine.sv
// Directed bench for ram_mult_engine: default build plus a 16-bit, RD_LAT=2, MUL_STAGES=1 build,
// each with its own RAM model and per-cycle protocol monitor.
module tb_ram_mult_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic clr;
    logic mon_clr;
    logic hps_we0;
    logic hps_we1;
    logic [7:0]  hps_addr;
    logic [31:0] hps_wdata;

    logic [7:0]  addr0;
    logic        cs0, ck0, wr0, busy0, done0;
    logic [31:0] wd0, rd0;
    logic [3:0]  be0;

    logic [7:0]  addr1;
    logic        cs1, ck1, wr1, busy1, done1;
    logic [15:0] wd1, rd1, rd1_q1;
    logic [1:0]  be1;

    logic [31:0] mem0 [256];
    logic [15:0] mem1 [256];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    ram_mult_engine u_dut0 (
        .clk(clk), .reset(reset),
        .ram_address(addr0), .ram_chipselect(cs0), .ram_clken(ck0), .ram_write(wr0),
        .ram_writedata(wd0), .ram_byteenable(be0), .ram_readdata(rd0),
        .busy(busy0), .done_pulse(done0)
    );

    ram_mult_engine #(.DATA_W(16), .RD_LAT(2), .MUL_STAGES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .ram_address(addr1), .ram_chipselect(cs1), .ram_clken(ck1), .ram_write(wr1),
        .ram_writedata(wd1), .ram_byteenable(be1), .ram_readdata(rd1),
        .busy(busy1), .done_pulse(done1)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
        end else begin
            if (hps_we0) mem0[hps_addr] <= hps_wdata;
            if (hps_we1) mem1[hps_addr] <= hps_wdata[15:0];
            if (cs0 && wr0) mem0[addr0] <= wd0;
            if (cs1 && wr1) mem1[addr1] <= wd1;
        end
        if (cs0 && !wr0) rd0 <= mem0[addr0];
        if (cs1 && !wr1) rd1_q1 <= mem1[addr1];
        rd1 <= rd1_q1;
    end

    // Monitor state: protocol violations, write counts, CSR write cycles, busy/done counts.
    int bad0 = 0, blk0 = 0, win0 = 0, wres0 = 0, wany0 = 0, rdc0 = 0, rdp0 = 0, rdprev0 = 0;
    int st0 = 0, fn0 = 0, dn0 = 0, bz0 = 0;
    int bad1 = 0, blk1 = 0, win1 = 0, wres1 = 0, wany1 = 0, rdc1 = 0, rdp1 = 0, rdprev1 = 0;
    int st1 = 0, fn1 = 0, dn1 = 0, bz1 = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (ck0 !== cs0) bad0 <= bad0 + 1;
            if (be0 !== (cs0 ? 4'hF : 4'h0)) bad0 <= bad0 + 1;
            if (done0 !== (cs0 && wr0 && addr0 == 8'd0 && wd0[2])) bad0 <= bad0 + 1;
            if (blk0 > 0 && cs0) bad0 <= bad0 + 1;
            if (cs0 && wr0 && addr0 != 8'd0 && (int'(addr0) < 64 || int'(addr0) >= 64 + win0))
                bad0 <= bad0 + 1;
            blk0 <= (cs0 && !wr0) ? 1 : ((blk0 > 0) ? blk0 - 1 : 0);
            if (mon_clr) begin
                wres0 <= 0; wany0 <= 0; rdc0 <= 0; rdp0 <= 0; rdprev0 <= cyc;
                st0 <= 0; fn0 <= 0; dn0 <= 0; bz0 <= 0;
            end else begin
                if (cs0 && !wr0) begin
                    rdc0 <= rdc0 + 1; rdp0 <= cyc - rdprev0; rdprev0 <= cyc;
                end
                if (cs0 && wr0) begin
                    wany0 <= wany0 + 1;
                    if (addr0 != 8'd0) wres0 <= wres0 + 1;
                    else begin
                        if (wd0[1]) st0 <= cyc;
                        if (wd0[2]) fn0 <= cyc;
                    end
                end
                if (busy0) bz0 <= bz0 + 1;
                if (done0) dn0 <= dn0 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (ck1 !== cs1) bad1 <= bad1 + 1;
            if (be1 !== (cs1 ? 2'h3 : 2'h0)) bad1 <= bad1 + 1;
            if (done1 !== (cs1 && wr1 && addr1 == 8'd0 && wd1[2])) bad1 <= bad1 + 1;
            if (blk1 > 0 && cs1) bad1 <= bad1 + 1;
            if (cs1 && wr1 && addr1 != 8'd0 && (int'(addr1) < 64 || int'(addr1) >= 64 + win1))
                bad1 <= bad1 + 1;
            blk1 <= (cs1 && !wr1) ? 2 : ((blk1 > 0) ? blk1 - 1 : 0);
            if (mon_clr) begin
                wres1 <= 0; wany1 <= 0; rdc1 <= 0; rdp1 <= 0; rdprev1 <= cyc;
                st1 <= 0; fn1 <= 0; dn1 <= 0; bz1 <= 0;
            end else begin
                if (cs1 && !wr1) begin
                    rdc1 <= rdc1 + 1; rdp1 <= cyc - rdprev1; rdprev1 <= cyc;
                end
                if (cs1 && wr1) begin
                    wany1 <= wany1 + 1;
                    if (addr1 != 8'd0) wres1 <= wres1 + 1;
                    else begin
                        if (wd1[1]) st1 <= cyc;
                        if (wd1[2]) fn1 <= cyc;
                    end
                end
                if (busy1) bz1 <= bz1 + 1;
                if (done1) dn1 <= dn1 + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        step(1);
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic clear_all();
        step(1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        mon_clear();
    endtask

    task automatic hps_wr0(input int a, input logic [31:0] d);
        step(1);
        hps_addr = 8'(a); hps_wdata = d; hps_we0 = 1'b1;
        step(1);
        hps_we0 = 1'b0;
    endtask

    task automatic hps_wr1(input int a, input logic [15:0] d);
        step(1);
        hps_addr = 8'(a); hps_wdata = {16'h0, d}; hps_we1 = 1'b1;
        step(1);
        hps_we1 = 1'b0;
    endtask

    task automatic run0(input logic [31:0] csr, input int win);
        bit seen = 1'b0;
        win0 = win;
        hps_wr0(0, csr);
        for (int k = 0; k < 2000 && !seen; k++) begin
            step(1);
            seen = mem0[0][2];
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL run0_timeout: csr=%h, required DONE bit within 2000 cycles", mem0[0]);
        end
        step(3);
    endtask

    task automatic run1(input logic [15:0] csr, input int win);
        bit seen = 1'b0;
        win1 = win;
        hps_wr1(0, csr);
        for (int k = 0; k < 2000 && !seen; k++) begin
            step(1);
            seen = mem1[0][2];
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL run1_timeout: csr=%h, required DONE bit within 2000 cycles", mem1[0]);
        end
        step(3);
    endtask

    task automatic test_reset();
        step(3);
        n_cmp++;
        if ({addr0, cs0, ck0, wr0, wd0, be0, busy0, done0} !== '0) begin
            n_bad++;
            $display("FAIL reset_out0: addr=%h cs=%b wr=%b wd=%h be=%h busy=%b done=%b, required all 0",
                     addr0, cs0, wr0, wd0, be0, busy0, done0);
        end
        n_cmp++;
        if ({addr1, cs1, ck1, wr1, wd1, be1, busy1, done1} !== '0) begin
            n_bad++;
            $display("FAIL reset_out1: addr=%h cs=%b wr=%b wd=%h be=%h busy=%b done=%b, required all 0",
                     addr1, cs1, wr1, wd1, be1, busy1, done1);
        end
        clr = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic test_unsigned();
        clear_all();
        hps_wr0(1, 32'hFFFF_FFFF);
        hps_wr0(2, 32'h0000_0002);
        run0(32'h0000_0101, 2);
        n_cmp++;
        if (mem0[64] !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL unsigned_lo: got %h, required fffffffe", mem0[64]);
        end
        n_cmp++;
        if (mem0[65] !== 32'h0000_0001) begin
            n_bad++; $display("FAIL unsigned_hi: got %h, required 00000001", mem0[65]);
        end
        n_cmp++;
        if (mem0[0] !== 32'h0000_0104) begin
            n_bad++; $display("FAIL unsigned_csr: got %h, required 00000104", mem0[0]);
        end
        n_cmp++;
        if (dn0 !== 1) begin
            n_bad++; $display("FAIL unsigned_done_pulses: got %0d, required 1", dn0);
        end
        n_cmp++;
        if (bz0 !== 11) begin
            n_bad++; $display("FAIL unsigned_busy_cycles: got %0d, required 11", bz0);
        end
        n_cmp++;
        if (wres0 !== 2 || busy0 !== 1'b0) begin
            n_bad++; $display("FAIL unsigned_writes: got %0d writes busy=%b, required 2 and 0", wres0, busy0);
        end
    endtask

    task automatic test_signed();
        clear_all();
        hps_wr0(1, 32'hFFFF_FFFD);
        hps_wr0(2, 32'h0000_0005);
        run0(32'h0000_0109, 2);
        n_cmp++;
        if (mem0[64] !== 32'hFFFF_FFF1 || mem0[65] !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL signed_prod: got %h_%h, required ffffffff_fffffff1", mem0[65], mem0[64]);
        end
        n_cmp++;
        if (mem0[0] !== 32'h0000_010C) begin
            n_bad++; $display("FAIL signed_csr: got %h, required 0000010c", mem0[0]);
        end
        clear_all();
        hps_wr0(1, 32'hFFFF_FFFD);
        hps_wr0(2, 32'h0000_0005);
        run0(32'h0000_0101, 2);
        n_cmp++;
        if (mem0[64] !== 32'hFFFF_FFF1 || mem0[65] !== 32'h0000_0004) begin
            n_bad++; $display("FAIL signed_as_unsigned: got %h_%h, required 00000004_fffffff1", mem0[65], mem0[64]);
        end
    endtask

    task automatic test_multi();
        clear_all();
        for (int i = 0; i < 16; i++) begin
            hps_wr0(1 + 2*i, 32'(i + 1));
            hps_wr0(2 + 2*i, 32'(i + 2));
        end
        run0(32'h0000_1001, 32);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (mem0[64 + 2*i] !== 32'((i + 1) * (i + 2)) || mem0[65 + 2*i] !== 32'h0) begin
                n_bad++;
                $display("FAIL multi_pair%0d: got %h_%h, required 00000000_%h",
                         i, mem0[65 + 2*i], mem0[64 + 2*i], 32'((i + 1) * (i + 2)));
            end
        end
        n_cmp++;
        if (mem0[0] !== 32'h0000_1004) begin
            n_bad++; $display("FAIL multi_csr: got %h, required 00001004", mem0[0]);
        end
        n_cmp++;
        if (fn0 - st0 !== 145) begin
            n_bad++; $display("FAIL multi_latency: got %0d, required 145", fn0 - st0);
        end
        n_cmp++;
        if (wres0 !== 32) begin
            n_bad++; $display("FAIL multi_writes: got %0d, required 32", wres0);
        end
    endtask

    task automatic test_multi_cfg2();
        clear_all();
        for (int i = 0; i < 16; i++) begin
            hps_wr1(1 + 2*i, 16'(i + 1));
            hps_wr1(2 + 2*i, 16'(i + 2));
        end
        run1(16'h1001, 32);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (mem1[64 + 2*i] !== 16'((i + 1) * (i + 2)) || mem1[65 + 2*i] !== 16'h0) begin
                n_bad++;
                $display("FAIL cfg2_pair%0d: got %h_%h, required 0000_%h",
                         i, mem1[65 + 2*i], mem1[64 + 2*i], 16'((i + 1) * (i + 2)));
            end
        end
        n_cmp++;
        if (mem1[0] !== 16'h1004) begin
            n_bad++; $display("FAIL cfg2_csr: got %h, required 1004", mem1[0]);
        end
        n_cmp++;
        if (fn1 - st1 !== 145) begin
            n_bad++; $display("FAIL cfg2_latency: got %0d, required 145", fn1 - st1);
        end
    endtask

    task automatic test_count_bounds();
        clear_all();
        run0(32'h0000_0001, 0);
        n_cmp++;
        if (mem0[0] !== 32'h0000_0004 || wres0 !== 0 || dn0 !== 1) begin
            n_bad++;
            $display("FAIL count0: csr=%h writes=%0d pulses=%0d, required 00000004/0/1", mem0[0], wres0, dn0);
        end
        clear_all();
        run0(32'h0000_1101, 0);
        n_cmp++;
        if (mem0[0] !== 32'h0000_1114 || wres0 !== 0) begin
            n_bad++;
            $display("FAIL count17: csr=%h writes=%0d, required 00001114/0", mem0[0], wres0);
        end
    endtask

    task automatic test_no_go();
        clear_all();
        step(120);
        n_cmp++;
        if (rdp0 !== 18 || wany0 !== 0 || rdc0 < 6) begin
            n_bad++;
            $display("FAIL nogo0: period=%0d writes=%0d reads=%0d, required 18/0/>=6", rdp0, wany0, rdc0);
        end
        n_cmp++;
        if (rdp1 !== 19 || wany1 !== 0) begin
            n_bad++;
            $display("FAIL nogo1: period=%0d writes=%0d, required 19/0", rdp1, wany1);
        end
    endtask

    task automatic test_reset_mid_job();
        bit hit = 1'b0;
        clear_all();
        for (int i = 0; i < 8; i++) begin
            hps_wr0(1 + 2*i, 32'h8000_0000 + 32'(i));
            hps_wr0(2 + 2*i, 32'h0000_0004);
        end
        win0 = 16;
        hps_wr0(0, 32'h0000_0801);
        for (int k = 0; k < 1000 && !hit; k++) begin
            @(negedge clk);
            hit = cs0 && wr0 && (addr0 == 8'd70);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++; $display("FAIL midrst_wait: WR_LO of pair 3 not seen, required within 1000 cycles");
        end
        reset = 1'b1;
        step(1);
        n_cmp++;
        if ({addr0, cs0, ck0, wr0, wd0, be0, busy0, done0} !== '0) begin
            n_bad++;
            $display("FAIL midrst_out: addr=%h cs=%b wr=%b wd=%h busy=%b, required all 0",
                     addr0, cs0, wr0, wd0, busy0);
        end
        reset = 1'b0;
        mon_clear();
        step(60);
        n_cmp++;
        if (wany0 !== 0 || mem0[0] !== 32'h0000_0802) begin
            n_bad++;
            $display("FAIL midrst_norestart: writes=%0d csr=%h, required 0/00000802", wany0, mem0[0]);
        end
        run0(32'h0000_0801, 16);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem0[64 + 2*i] !== 32'(4 * i) || mem0[65 + 2*i] !== 32'h2) begin
                n_bad++;
                $display("FAIL midrst_pair%0d: got %h_%h, required 00000002_%h",
                         i, mem0[65 + 2*i], mem0[64 + 2*i], 32'(4 * i));
            end
        end
        n_cmp++;
        if (mem0[0] !== 32'h0000_0804 || dn0 !== 1) begin
            n_bad++; $display("FAIL midrst_csr: csr=%h pulses=%0d, required 00000804/1", mem0[0], dn0);
        end
    endtask

    task automatic test_protocol();
        step(2);
        n_cmp++;
        if (bad0 !== 0) begin
            n_bad++; $display("FAIL protocol0: got %0d violations, required 0", bad0);
        end
        n_cmp++;
        if (bad1 !== 0) begin
            n_bad++; $display("FAIL protocol1: got %0d violations, required 0", bad1);
        end
    endtask

    initial begin
        reset = 1'b1;
        clr = 1'b1;
        mon_clr = 1'b1;
        hps_we0 = 1'b0;
        hps_we1 = 1'b0;
        hps_addr = '0;
        hps_wdata = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_multi();
        test_multi_cfg2();
        test_count_bounds();
        test_no_go();
        test_reset_mid_job();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
